ec_control_unit: RTL and testbench



---
 rtl/ec_control_unit.sv | 146 ++++++++++++++
 tb/tb_ec_control_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ec_control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator processor.
// Optional single-step mode is enabled by defining CU_SINGLE_STEP_EN.
module ec_control_unit (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RamInit,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
`ifdef CU_SINGLE_STEP_EN
    input  logic       Step,
`endif
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_DEC   = 4'd2,
        S_LOAD  = 4'd3,
        S_STORE = 4'd4,
        S_ADD   = 4'd5,
        S_SUB   = 4'd6,
        S_INPUT = 4'd7,
        S_INREL = 4'd8,
        S_JZ    = 4'd9,
        S_JPOS  = 4'd10,
        S_HALT  = 4'd11,
        S_STEP  = 4'd12
    } state_t;

    state_t state_q, state_d;

`ifdef CU_SINGLE_STEP_EN
    localparam state_t POST_EXEC = S_STEP;
    logic step_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) step_q <= 1'b0;
        else        step_q <= Step;
    end
`else
    localparam state_t POST_EXEC = S_FETCH;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Asel    = 2'b00;
        Halt    = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                IRload  = 1'b1;
                PCload  = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                // Operand address goes to RAM now so RamQ is valid in the execute state
                Meminst = 1'b1;
                case (IR)
                    3'b000:  state_d = S_LOAD;
                    3'b001:  state_d = S_STORE;
                    3'b010:  state_d = S_ADD;
                    3'b011:  state_d = S_SUB;
                    3'b100:  state_d = S_INPUT;
                    3'b101:  state_d = S_JZ;
                    3'b110:  state_d = S_JPOS;
                    default: state_d = S_HALT;
                endcase
            end
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = 1'b1;
                state_d = POST_EXEC;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
                state_d = POST_EXEC;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                state_d = POST_EXEC;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = 1'b1;
                state_d = POST_EXEC;
            end
            S_INPUT: begin
                Asel  = 2'b01;
                Aload = Enter;
                if (Enter) state_d = S_INREL;
            end
            // Wait for release so a held button loads only once
            S_INREL: if (!Enter) state_d = POST_EXEC;
            S_JZ: begin
                JMPmux  = 1'b1;
                PCload  = Aeq0;
                state_d = POST_EXEC;
            end
            S_JPOS: begin
                JMPmux  = 1'b1;
                PCload  = Apos;
                state_d = POST_EXEC;
            end
            S_HALT: begin
                Halt    = 1'b1;
                state_d = S_HALT;
            end
`ifdef CU_SINGLE_STEP_EN
            S_STEP: if (Step && !step_q) state_d = S_FETCH;
`endif
            default: state_d = S_IDLE;
        endcase
        if (RamInit) state_d = S_IDLE;
    end

    assign State = state_q;

endmodule

// File: tb/tb_ec_control_unit.sv
// Directed self-checking bench for ec_control_unit; also covers single-step mode
// when compiled with CU_SINGLE_STEP_EN.
module tb_ec_control_unit;

    logic       Clock = 1'b0;
    logic       Reset, RamInit, Aeq0, Apos, Enter;
    logic [2:0] IR;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] State;
`ifdef CU_SINGLE_STEP_EN
    logic       Step = 1'b0;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Asel,Halt}
    wire [9:0] outs = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt};

    localparam logic [9:0] O_ZERO  = 10'b0000000000;
    localparam logic [9:0] O_FETCH = 10'b1010000000;
    localparam logic [9:0] O_DEC   = 10'b0001000000;
    localparam logic [9:0] O_LOAD  = 10'b0001010100;
    localparam logic [9:0] O_STORE = 10'b0001100000;
    localparam logic [9:0] O_ADD   = 10'b0001010000;
    localparam logic [9:0] O_SUB   = 10'b0001011000;
    localparam logic [9:0] O_IN0   = 10'b0000000010;
    localparam logic [9:0] O_IN1   = 10'b0000010010;
    localparam logic [9:0] O_JMPT  = 10'b0110000000;
    localparam logic [9:0] O_JMPN  = 10'b0100000000;
    localparam logic [9:0] O_HALT  = 10'b0000000001;

    ec_control_unit dut (
        .Clock(Clock), .Reset(Reset), .RamInit(RamInit), .IR(IR),
        .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
`ifdef CU_SINGLE_STEP_EN
        .Step(Step),
`endif
        .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
        .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt),
        .State(State)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_so(input string name, input logic [3:0] es, input logic [9:0] eo);
        total_cnt++;
        if (State !== es || outs !== eo)
            $display("FAIL %s: State=%0d outs=%b, expected State=%0d outs=%b", name, State, outs, es, eo);
        else
            pass_cnt++;
    endtask

    // Leaves an execute state and lands in FETCH (through STEP when single-stepping)
    task automatic post_exec(input string name);
        tick();
`ifdef CU_SINGLE_STEP_EN
        check_so({name, "_step"}, 4'd12, O_ZERO);
        Step = 1'b0;
        tick();
        Step = 1'b1;
        tick();
`endif
        check_so({name, "_fetch"}, 4'd1, O_FETCH);
    endtask

    task automatic test_reset();
        Reset = 1'b0; RamInit = 1'b0; IR = 3'b010; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
        #3;
        check_so("reset_state", 4'd0, O_ZERO);
        Reset = 1'b1;
        tick();
        check_so("first_fetch", 4'd1, O_FETCH);
        tick();
        check_so("add_decode", 4'd2, O_DEC);
        tick();
        check_so("add_exec", 4'd5, O_ADD);
        #2;
        Reset = 1'b0;
        #1;
        check_so("async_reset_mid_add", 4'd0, O_ZERO);
        #1;
        Reset = 1'b1;
        tick();
        check_so("fetch_after_reset", 4'd1, O_FETCH);
    endtask

    task automatic test_load();
        IR = 3'b000;
        tick();
        check_so("load_decode", 4'd2, O_DEC);
        tick();
        check_so("load_exec", 4'd3, O_LOAD);
        post_exec("load");
    endtask

    task automatic test_jump();
        IR = 3'b101; Aeq0 = 1'b1;
        tick(); tick();
        check_so("jz_taken", 4'd9, O_JMPT);
        Aeq0 = 1'b0;
        #1;
        check_so("jz_not_taken", 4'd9, O_JMPN);
        post_exec("jz");
        IR = 3'b110; Apos = 1'b1;
        tick(); tick();
        check_so("jpos_taken", 4'd10, O_JMPT);
        Apos = 1'b0;
        #1;
        check_so("jpos_not_taken", 4'd10, O_JMPN);
        post_exec("jpos");
    endtask

    task automatic test_input();
        int aload_cnt = 0;
        IR = 3'b100; Enter = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check_so("input_wait", 4'd7, O_IN0);
            aload_cnt += int'(Aload);
            if (i < 4) tick();
        end
        Enter = 1'b1;
        #1;
        check_so("input_load", 4'd7, O_IN1);
        aload_cnt += int'(Aload);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_so("inrel_hold", 4'd8, O_ZERO);
            aload_cnt += int'(Aload);
        end
        Enter = 1'b0;
        post_exec("input");
        total_cnt++;
        if (aload_cnt !== 1)
            $display("FAIL input_single_load: Aload pulses=%0d, expected 1", aload_cnt);
        else
            pass_cnt++;
    endtask

    task automatic test_halt();
        int bad = 0;
        IR = 3'b111;
        tick(); tick();
        check_so("halt_entry", 4'd11, O_HALT);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (State !== 4'd11 || outs !== O_HALT) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL halt_persist: %0d cycles left HALT, expected 0", bad);
        else
            pass_cnt++;
        RamInit = 1'b1;
        tick();
        check_so("raminit_1", 4'd0, O_ZERO);
        tick();
        check_so("raminit_2", 4'd0, O_ZERO);
        RamInit = 1'b0;
        tick();
        check_so("raminit_release", 4'd1, O_FETCH);
    endtask

    task automatic test_sub_store();
        IR = 3'b011;
        tick(); tick();
        check_so("sub_exec", 4'd6, O_SUB);
        post_exec("sub");
        IR = 3'b001;
        tick(); tick();
        check_so("store_exec", 4'd4, O_STORE);
        post_exec("store");
    endtask

`ifdef CU_SINGLE_STEP_EN
    task automatic test_step();
        int bad = 0;
        Step = 1'b1; IR = 3'b001;
        tick(); tick();
        check_so("step_store", 4'd4, O_STORE);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (State !== 4'd12 || outs !== O_ZERO) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL step_held_high: %0d cycles left STEP, expected 0", bad);
        else
            pass_cnt++;
        Step = 1'b0;
        tick();
        check_so("step_low", 4'd12, O_ZERO);
        Step = 1'b1;
        tick();
        check_so("step_rise", 4'd1, O_FETCH);
        tick(); tick(); tick();
        check_so("step_once_only", 4'd12, O_ZERO);
        tick();
        check_so("step_still_held", 4'd12, O_ZERO);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_jump();
        test_input();
        test_halt();
        test_sub_store();
`ifdef CU_SINGLE_STEP_EN
        test_step();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
